arp_rx: RTL
===========

Name: arp_rx

Overview:
- Receive-side ARP parser: the writer that fills the ip2mac cache.
- Consumes the byte stream of an Ethernet payload whose ethertype is 0x0806 (header already stripped by the MAC RX path).
- Validates the 28-byte ARP body and commits a sender IP→MAC binding through the cache write port (ip_i/mac_i/wea).
- Flags ARP requests addressed to this host so the ARP TX block can answer.

Parameters:
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- local_ip, input, 32, this host's IPv4 address.
- rx_data, input, 8, payload byte.
- rx_valid, input, 1, rx_data/rx_sof/rx_eof valid this cycle.
- rx_sof, input, 1, first byte of the frame payload.
- rx_eof, input, 1, last byte of the frame payload.
- ip_i, output, 32, sender protocol address (SPA) to write into the cache.
- mac_i, output, 48, sender hardware address (SHA) to write into the cache.
- wea, output, 1, one-cycle cache write strobe.
- reply_req, output, 1, one-cycle pulse: a request targeted local_ip.
- peer_ip, output, 32, SPA held for the ARP TX block.
- peer_mac, output, 48, SHA held for the ARP TX block.
- ok_cnt, output, CNT_W, frames committed.
- drop_cnt, output, CNT_W, frames dropped.

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE; byte counter is 0.
  - Reset mid-frame abandons the frame without incrementing any counter.
  - Remaining bytes of an abandoned frame are ignored until the next rx_sof.
- Only beats with rx_valid=1 are consumed; rx_valid=0 stalls parsing with no state change.
- States: IDLE, PARSE, DROP, COMMIT.
- IDLE:
  - rx_sof beat → load byte 0, go to PARSE.
  - Non-sof beats are ignored.
- Byte offsets 0-27 (big-endian fields):
  - HTYPE 0-1 = 0x0001.
  - PTYPE 2-3 = 0x0800.
  - HLEN 4 = 0x06.
  - PLEN 5 = 0x04.
  - OPER 6-7 = 0x0001 or 0x0002.
  - SHA 8-13.
  - SPA 14-17.
  - THA 18-23 (ignored).
  - TPA 24-27.
- Each fixed-field byte is checked as it arrives. A mismatch, or OPER not 1 or 2, → DROP.
- SHA and SPA shift into holding registers; the TPA comparison with local_ip is done bytewise.
- Bytes past offset 27 (Ethernet padding, up to 46-byte payload) are ignored; the byte counter saturates at 28.
- rx_sof during PARSE or DROP aborts the current frame: drop_cnt+1, restart at byte 0 with this beat.
- rx_eof in PARSE:
  - Counter ≥ 27 including this beat → COMMIT.
  - Otherwise → drop_cnt+1, back to IDLE (short frame).
- rx_eof in DROP → drop_cnt+1, IDLE.
- rx_sof and rx_eof on the same beat → dropped (short frame).
- COMMIT (exactly one cycle, the cycle after the eof beat):
  - Write condition: SPA ≠ 0.0.0.0 and SHA bit 40 (I/G bit) = 0.
  - Condition true → wea=1, ip_i=SPA, mac_i=SHA, ok_cnt+1.
  - Condition false → no write, drop_cnt+1.
  - OPER=1 and TPA=local_ip, together with the write condition → reply_req=1; peer_ip/peer_mac load SPA/SHA.
  - Next state is IDLE. An rx_sof beat arriving in COMMIT is accepted and starts PARSE at byte 1.
- Latency: eof beat at cycle N → wea/reply_req at N+1.
- ip_i/mac_i are held until the next commit. peer_ip/peer_mac are held until the next reply_req.
- Counters saturate at all-ones (no wrap).
- local_ip is sampled at TPA compare time; changes during a frame affect only the bytes not yet compared.

Test Plan:
- Reply: OPER=2, SHA 9c:eb:e8:22:fd:18, SPA 10.214.128.234, 28 bytes back-to-back → one cycle after eof: wea=1, ip_i=0x0ad680ea, mac_i=0x9cebe822fd18, reply_req=0, ok_cnt=1.
- Request to us: local_ip=0x0ad680ea; OPER=1, SHA 9c:eb:e8:22:fd:19, SPA 11.214.128.234, TPA 10.214.128.234 → wea=1 and reply_req=1 in the same cycle, peer_ip=0x0bd680ea, peer_mac=0x9cebe822fd19. Repeat with TPA 10.214.128.235 → wea=1, reply_req=0.
- Malformed:
  - PTYPE 0x86dd → no wea, drop_cnt+1.
  - 20-byte frame ending in eof → no wea, drop_cnt+1.
  - SPA 0.0.0.0 → no wea, drop_cnt+1.
- Padding and stalls: valid reply padded to 46 bytes with rx_valid toggling every other cycle → exactly one wea, one cycle after the eof beat, with correct SPA/SHA.
- Abort/reset:
  - rx_sof at byte 10, then a full valid frame → drop_cnt+1, then one wea with the second frame's data.
  - reset at byte 15 → all outputs 0; following bytes without sof produce no wea.
- Back-to-back frames: sof of frame 2 in the COMMIT cycle of frame 1 → two wea pulses, each with its own frame's data; ok_cnt=2.

Source files
------------

// File: rtl/arp_rx.sv
// Receive-side ARP parser: validates a 28-byte ARP body and writes the sender
// IP->MAC binding into the ip2mac cache, flagging requests aimed at this host.
module arp_rx #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      local_ip,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_sof,
  input  logic             rx_eof,
  output logic [31:0]      ip_i,
  output logic [47:0]      mac_i,
  output logic             wea,
  output logic             reply_req,
  output logic [31:0]      peer_ip,
  output logic [47:0]      peer_mac,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, PARSE, DROP, COMMIT} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, off, cnt_n;
  logic [47:0] sha, sha_n;
  logic [31:0] spa, spa_n;
  logic        oper_req, oper_req_n;
  logic        tpa_hit, tpa_hit_n;
  logic        byte_ok, wr_ok, load, commit_go;
  logic [1:0]  drop_inc;

  // Fixed header bytes; offsets past the OPER field carry no constraint.
  function automatic logic field_ok(input logic [4:0] o, input logic [7:0] b);
    case (o)
      5'd0, 5'd3, 5'd6: field_ok = (b == 8'h00);
      5'd1:             field_ok = (b == 8'h01);
      5'd2:             field_ok = (b == 8'h08);
      5'd4:             field_ok = (b == 8'h06);
      5'd5:             field_ok = (b == 8'h04);
      5'd7:             field_ok = (b == 8'h01) || (b == 8'h02);
      default:          field_ok = 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [4:0] o, input logic [31:0] ip);
    case (o[1:0])
      2'd0:    ip_byte = ip[31:24];
      2'd1:    ip_byte = ip[23:16];
      2'd2:    ip_byte = ip[15:8];
      default: ip_byte = ip[7:0];
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    sat_add = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Per-beat datapath: a sof beat always restarts at offset 0.
  always_comb begin
    off        = rx_sof ? 5'd0 : cnt;
    cnt_n      = (off == 5'd28) ? 5'd28 : off + 5'd1;
    byte_ok    = field_ok(off, rx_data);
    sha_n      = sha;
    spa_n      = spa;
    oper_req_n = oper_req;
    tpa_hit_n  = rx_sof ? 1'b1 : tpa_hit;
    if (off >= 5'd8 && off <= 5'd13)
      sha_n = {sha[39:0], rx_data};
    if (off >= 5'd14 && off <= 5'd17)
      spa_n = {spa[23:0], rx_data};
    if (off == 5'd7)
      oper_req_n = (rx_data == 8'h01);
    if (off >= 5'd24 && off <= 5'd27 && rx_data != ip_byte(off, local_ip))
      tpa_hit_n = 1'b0;
    wr_ok = (spa_n != 32'd0) && !sha_n[40];
  end

  always_comb begin
    state_n   = (state == COMMIT) ? IDLE : state;
    load      = 1'b0;
    drop_inc  = 2'd0;
    commit_go = 1'b0;
    if (rx_valid) begin
      if (rx_sof) begin
        load = 1'b1;
        if (state == PARSE || state == DROP)
          drop_inc = 2'd1;
        if (rx_eof) begin
          drop_inc = drop_inc + 2'd1;
          state_n  = IDLE;
        end else begin
          state_n = byte_ok ? PARSE : DROP;
        end
      end else if (state == PARSE) begin
        load = 1'b1;
        if (rx_eof) begin
          if (byte_ok && off >= 5'd27) begin
            commit_go = 1'b1;
            state_n   = COMMIT;
            if (!wr_ok)
              drop_inc = 2'd1;
          end else begin
            drop_inc = 2'd1;
            state_n  = IDLE;
          end
        end else if (!byte_ok) begin
          state_n = DROP;
        end
      end else if (state == DROP && rx_eof) begin
        drop_inc = 2'd1;
        state_n  = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sha <= sha_n;
      spa <= spa_n;
    end
  end

  // Commit outputs are registered at the eof edge, so they show in the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      oper_req  <= 1'b0;
      tpa_hit   <= 1'b0;
      ip_i      <= 32'd0;
      mac_i     <= 48'd0;
      wea       <= 1'b0;
      reply_req <= 1'b0;
      peer_ip   <= 32'd0;
      peer_mac  <= 48'd0;
      ok_cnt    <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      wea       <= 1'b0;
      reply_req <= 1'b0;
      if (load) begin
        cnt      <= cnt_n;
        oper_req <= oper_req_n;
        tpa_hit  <= tpa_hit_n;
      end
      if (drop_inc != 2'd0)
        drop_cnt <= sat_add(drop_cnt, drop_inc);
      if (commit_go && wr_ok) begin
        wea    <= 1'b1;
        ip_i   <= spa_n;
        mac_i  <= sha_n;
        ok_cnt <= sat_add(ok_cnt, 2'd1);
        if (oper_req_n && tpa_hit_n) begin
          reply_req <= 1'b1;
          peer_ip   <= spa_n;
          peer_mac  <= sha_n;
        end
      end
    end
  end

endmodule
